// File: rtl/fsm_seq_detect_param.sv
// fsm_seq_detect_param: serial pattern detector over the last PAT_LEN accepted bits.
// y0 is the same-cycle (Mealy) match and y1 the registered (Moore) HIT flag.
// hit_cnt is a saturating match counter with a synchronous clear.
module fsm_seq_detect_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic               clr_cnt,
  output logic               y0,
  output logic               y1,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [1:0]         st
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2,
    HIT   = 2'd3
  } state_t;

  // fill saturates here: the history is full and every new sample completes a window
  localparam logic [4:0]       FULL    = 5'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_nxt;
  logic [PAT_LEN-2:0] hist, hist_nxt;
  logic [4:0]         fill, fill_nxt;
  logic [PAT_LEN-1:0] win;

  // Newest bit sits at the LSB, so pattern[PAT_LEN-1] lines up with the oldest bit.
  assign win = {hist, din};
  assign y0  = en && (fill == FULL) && (win == pattern);
  assign st  = state;

  // Next history/fill and next state; a non-overlapping match throws the window away.
  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    if (en) begin
      hist_nxt = win[PAT_LEN-2:0];
      if (y0 && overlap) begin
        fill_nxt = FULL;
      end else if (y0) begin
        fill_nxt = '0;
        hist_nxt = '0;
      end else if (fill < FULL) begin
        fill_nxt = fill + 5'd1;
      end
    end
    // With en=0 outside HIT, fill holds, so the decode reproduces the current state.
    if (y0)                  state_nxt = HIT;
    else if (fill_nxt == '0) state_nxt = IDLE;
    else if (fill_nxt < FULL) state_nxt = FILL;
    else                     state_nxt = ARMED;
  end

  // State, history and registered Moore flag; reset discards any partial window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hist  <= '0;
      fill  <= '0;
      y1    <= 1'b0;
    end else begin
      state <= state_nxt;
      hist  <= hist_nxt;
      fill  <= fill_nxt;
      y1    <= (state_nxt == HIT);
    end
  end

  // Saturating hit counter; clear takes priority over a coincident match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt <= '0;
    end else if (clr_cnt) begin
      hit_cnt <= '0;
    end else if (y0 && (hit_cnt != CNT_MAX)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fsm_seq_detect_param.sv
// Bench for fsm_seq_detect_param: a 4-bit/8-bit-counter instance (a) and a
// 2-bit/2-bit-counter instance (b) for saturation. Expected values are queued
// when a sample is driven and popped when the DUT answers.
module tb_fsm_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_a = 1'b0, din_a = 1'b0, overlap_a = 1'b1, clr_a = 1'b0;
  logic [3:0] pattern_a = 4'b1011;
  logic       y0_a, y1_a;
  logic [7:0] cnt_a;
  logic [1:0] st_a;
  logic       en_b = 1'b0, din_b = 1'b0, overlap_b = 1'b1, clr_b = 1'b0;
  logic [1:0] pattern_b = 2'b11;
  logic       y0_b, y1_b;
  logic [1:0] cnt_b;
  logic [1:0] st_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       y0;
    logic [1:0] st;
    logic [7:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fsm_seq_detect_param #(.PAT_LEN(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .din(din_a), .pattern(pattern_a),
    .overlap(overlap_a), .clr_cnt(clr_a), .y0(y0_a), .y1(y1_a),
    .hit_cnt(cnt_a), .st(st_a)
  );

  fsm_seq_detect_param #(.PAT_LEN(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .din(din_b), .pattern(pattern_b),
    .overlap(overlap_b), .clr_cnt(clr_b), .y0(y0_b), .y1(y1_b),
    .hit_cnt(cnt_b), .st(st_b)
  );

  // One sample cycle, entered and left on a negedge. y0 is checked before the
  // edge, st/y1/hit_cnt just after it.
  task automatic step(input bit sel, input logic e, input logic d, input logic c,
                      input logic ey0, input logic [1:0] est, input logic [7:0] ecnt,
                      input string nm);
    exp_t ex;
    logic oy0, oy1;
    logic [1:0] ost;
    logic [7:0] ocnt;
    if (sel) begin
      en_b = e; din_b = d; clr_b = c; en_a = 1'b0; clr_a = 1'b0;
    end else begin
      en_a = e; din_a = d; clr_a = c; en_b = 1'b0; clr_b = 1'b0;
    end
    exp_q.push_back('{ey0, est, ecnt});
    #2;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: queue empty", nm);
      return;
    end
    ex = exp_q.pop_front();
    oy0 = sel ? y0_b : y0_a;
    if (oy0 !== ex.y0) begin
      errors++;
      $display("FAIL %s y0: got %0b want %0b", nm, oy0, ex.y0);
    end
    @(posedge clk);
    #1;
    ost  = sel ? st_b : st_a;
    oy1  = sel ? y1_b : y1_a;
    ocnt = sel ? {6'd0, cnt_b} : cnt_a;
    checks++;
    if (ost !== ex.st) begin
      errors++;
      $display("FAIL %s st: got %0d want %0d", nm, ost, ex.st);
    end
    checks++;
    if (oy1 !== (ex.st == 2'd3)) begin
      errors++;
      $display("FAIL %s y1: got %0b want %0b", nm, oy1, (ex.st == 2'd3));
    end
    checks++;
    if (ocnt !== ex.cnt) begin
      errors++;
      $display("FAIL %s hit_cnt: got %0d want %0d", nm, ocnt, ex.cnt);
    end
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
  endtask

  // Assert reset with a tempting input, check both instances, release on a negedge.
  task automatic test_reset(input string nm);
    @(negedge clk);
    en_a = 1'b1; din_a = 1'b1; en_b = 1'b1; din_b = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if ({y0_a, y1_a, st_a, cnt_a} !== 12'd0) begin
      errors++;
      $display("FAIL %s a: y0=%0b y1=%0b st=%0d cnt=%0d want all 0", nm, y0_a, y1_a, st_a, cnt_a);
    end
    checks++;
    if ({y0_b, y1_b, st_b, cnt_b} !== 6'd0) begin
      errors++;
      $display("FAIL %s b: y0=%0b y1=%0b st=%0d cnt=%0d want all 0", nm, y0_b, y1_b, st_b, cnt_b);
    end
    en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_overlap();
    logic       d[7] = '{1, 0, 1, 1, 0, 1, 1};
    logic       y[7] = '{0, 0, 0, 1, 0, 0, 1};
    logic [1:0] s[7] = '{1, 1, 2, 3, 2, 2, 3};
    logic [7:0] c[7] = '{0, 0, 0, 1, 1, 1, 2};
    test_reset("reset_overlap");
    pattern_a = 4'b1011; overlap_a = 1'b1;
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, d[i], 1'b0, y[i], s[i], c[i], $sformatf("overlap_s%0d", i + 1));
    // Idle cycle in HIT with overlap: falls back to ARMED, count unchanged.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd2, "overlap_hit_idle");
  endtask

  // Runs straight after test_overlap: stale history 011 plus 1,0,1 leaves 101,
  // so a completing 1 would match if reset failed to wipe it.
  task automatic test_reset_midstream();
    logic d[3] = '{1, 0, 1};
    pattern_a = 4'b1011; overlap_a = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, d[i], 1'b0, 1'b0, 2'd2, 8'd2, $sformatf("midrst_s%0d", i + 1));
    en_a = 1'b1; din_a = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({y0_a, y1_a, st_a, cnt_a} !== 12'd0) begin
      errors++;
      $display("FAIL midrst_assert: y0=%0b y1=%0b st=%0d cnt=%0d want all 0", y0_a, y1_a, st_a, cnt_a);
    end
    #1;
    en_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, "midrst_after");
  endtask

  task automatic test_non_overlap();
    test_reset("reset_nonoverlap");
    pattern_a = 4'b1011; overlap_a = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, "nonov_s1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, "nonov_s2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, "nonov_s3");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd1, "nonov_s4");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, "nonov_hit_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1, "nonov_s5");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, "nonov_s6");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'd1, "nonov_s7");
  endtask

  task automatic test_en_gaps();
    test_reset("reset_gaps");
    pattern_a = 4'b1011; overlap_a = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, "gaps_s1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, "gaps_s2");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, $sformatf("gaps_idle%0d", i));
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, "gaps_s3");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd1, "gaps_s4");
  endtask

  task automatic test_saturate();
    logic       y[6] = '{0, 1, 1, 1, 1, 1};
    logic [1:0] s[6] = '{2, 3, 3, 3, 3, 3};
    logic [7:0] c[6] = '{0, 1, 2, 3, 3, 3};
    test_reset("reset_sat");
    pattern_b = 2'b11; overlap_b = 1'b1;
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, y[i], s[i], c[i], $sformatf("sat_s%0d", i + 1));
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 8'd0, "sat_clr_with_hit");
  endtask

  task automatic test_pattern_change();
    test_reset("reset_patchg");
    pattern_a = 4'b1101; overlap_a = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, "patchg_s1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, "patchg_s2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0, "patchg_s3");
    pattern_a = 4'b0101;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, "patchg_s4");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0, "patchg_s5");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd1, "patchg_s6");
  endtask

  initial begin
    test_reset("reset_initial");
    test_overlap();
    test_reset_midstream();
    test_non_overlap();
    test_en_gaps();
    test_saturate();
    test_pattern_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
